opb_swreg_slave: RTL and testbench
==================================

OPB_SWREG_SLAVE -- requirements
Module: opb_swreg_slave

Interface
REQ-001 Parameters SHALL be, one per line:
  C_BASEADDR, 32'h0100_0000, first byte address of the slave window
  C_HIGHADDR, 32'h0100_FFFF, last byte address of the slave window
  C_NUM_RW, 4, number of read/write registers driven to fabric (1..8)
  C_NUM_RO, 4, number of read-only registers sampled from fabric (1..8)
REQ-002 Ports SHALL be, one per line:
  OPB_Clk  input  1  sole clock, rising edge
  OPB_Rst  input  1  asynchronous, active-high reset
  OPB_select  input  1  master select / transfer valid
  OPB_RNW  input  1  1 = read, 0 = write
  OPB_ABus  input  [0:31]  byte address, bit 0 = MSB
  OPB_BE  input  [0:3]  byte enables; BE[0] covers DBus[0:7]
  OPB_seqAddr  input  1  sequential hint, ignored
  OPB_DBus  input  [0:31]  write data
  Sl_DBus  output  [0:31]  read data, zero when not acking
  Sl_xferAck  output  1  transfer acknowledge
  Sl_errAck  output  1  error acknowledge
  Sl_retry  output  1  tied 0
  Sl_toutSup  output  1  timeout suppress
  reg_out  output  C_NUM_RW*32  RW register contents, reg 0 in LSBs
  reg_wr_stb  output  C_NUM_RW  one-cycle pulse per register written
  reg_in  input  C_NUM_RO*32  fabric values for RO registers, reg 0 in LSBs

Function
REQ-003 Hit SHALL be OPB_select=1 and C_BASEADDR <= OPB_ABus <= C_HIGHADDR; word index = (OPB_ABus - C_BASEADDR) >> 2.
REQ-004 Index 0..C_NUM_RW-1 SHALL map to RW regs; C_NUM_RW..C_NUM_RW+C_NUM_RO-1 to RO regs; higher indices in window are unmapped.
REQ-005 FSM SHALL have states IDLE, ACK, HOLD; IDLE->ACK on hit; ACK->HOLD unconditionally; HOLD->IDLE unconditionally; non-hit in IDLE stays IDLE.
REQ-006 Sl_xferAck SHALL be 1 for exactly the one cycle in ACK, i.e. one cycle after hit is sampled; never asserted in IDLE or HOLD.
REQ-007 HOLD SHALL ignore OPB_select so a select still high after ack is not re-acknowledged.
REQ-008 Sl_toutSup SHALL be 1 in ACK only (ack always within 2 cycles, no suppression beyond).
REQ-009 Write to RW reg SHALL update only bytes with BE=1, on the edge ending the ACK cycle, and pulse reg_wr_stb[i] during ACK.
REQ-010 Write to RO reg SHALL be acked, data discarded, no strobe.
REQ-011 Read SHALL drive Sl_DBus during ACK with register value sampled at the IDLE->ACK edge; Sl_DBus=0 in all other cycles (OR-bus rule).
REQ-012 Unmapped index SHALL assert Sl_errAck together with Sl_xferAck in ACK, Sl_DBus=0, no register change.
REQ-013 Address, RNW, BE and write data SHALL be captured at the IDLE->ACK edge; changes during ACK have no effect.
REQ-014 Out-of-window select SHALL produce no output activity.

Reset
REQ-015 OPB_Rst=1 SHALL asynchronously force state IDLE, all RW regs 0, reg_wr_stb 0, Sl_xferAck/Sl_errAck/Sl_toutSup 0, Sl_DBus 0.
REQ-016 Reset asserted during ACK SHALL abort the transfer: ack withdrawn immediately, pending write not committed.
REQ-017 First hit after reset release SHALL be acked with normal one-cycle latency.

Structure
REQ-018 Package opb_swreg_pkg SHALL hold FSM state type, OPB data/address widths, and max register count constant (8).
REQ-019 Address window check and index/region decode SHALL be one sub-module, opb_swreg_decode; the rest stays in opb_swreg_slave.

Verification
REQ-020 Write 32'hDEAD_BEEF, BE=4'b1111, to base+0x0 -> xferAck one cycle after select, reg_out[31:0]=DEADBEEF, reg_wr_stb[0] one pulse.
REQ-021 Write 32'h1122_3344, BE=4'b0100, to base+0x4 over reg 1 = 0 -> reg 1 = 32'h0022_0000.
REQ-022 reg_in reg 0 = 32'hCAFE_0001, read base+0x10 (C_NUM_RW=4) -> Sl_DBus=CAFE0001 in ack cycle, 0 before and after.
REQ-023 Read base+0x20 -> Sl_xferAck and Sl_errAck both 1 for one cycle, Sl_DBus=0.
REQ-024 Hold select high 4 cycles on one write -> exactly one ack, one strobe.
REQ-025 Assert OPB_Rst in ACK cycle of write to base+0x0 -> ack drops that cycle, reg 0 stays 0.

Source files
------------

// File: rtl/opb_swreg_pkg.sv
// Shared types and constants for the OPB software-register slave.
package opb_swreg_pkg;

  localparam int unsigned OPB_AWIDTH = 32;
  localparam int unsigned OPB_DWIDTH = 32;
  localparam int unsigned MAX_REGS   = 8;
  localparam int unsigned IDX_W      = 3;

  typedef enum logic [1:0] {
    StIdle,
    StAck,
    StHold
  } swreg_state_e;

  typedef enum logic [1:0] {
    RegionRw,
    RegionRo,
    RegionUnmapped
  } swreg_region_e;

  // be[k] guards bits [8k+7:8k]; be[3] is the byte on OPB_DBus[0:7].
  function automatic logic [OPB_DWIDTH-1:0] be_merge(input logic [OPB_DWIDTH-1:0] old_val,
                                                     input logic [OPB_DWIDTH-1:0] new_val,
                                                     input logic [3:0]            be);
    logic [OPB_DWIDTH-1:0] res;
    res = old_val;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) res[8*k +: 8] = new_val[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/opb_swreg_decode.sv
// Address window check plus word-index to register region decode.
module opb_swreg_decode
  import opb_swreg_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR = 32'h0100_0000,
  parameter logic [31:0] C_HIGHADDR = 32'h0100_FFFF,
  parameter int unsigned C_NUM_RW   = 4,
  parameter int unsigned C_NUM_RO   = 4
) (
  input  logic                  select,
  input  logic [OPB_AWIDTH-1:0] abus,
  output logic                  hit,
  output swreg_region_e         region,
  output logic [IDX_W-1:0]      reg_idx
);

  logic [31:0] offset;
  logic [29:0] word_idx;
  logic [29:0] ro_idx;
  logic        unused_bits;

  assign offset   = abus - C_BASEADDR;
  assign word_idx = offset[31:2];
  assign ro_idx   = word_idx - 30'(C_NUM_RW);
  assign hit      = select && (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);

  always_comb begin
    region  = RegionUnmapped;
    reg_idx = '0;
    if (word_idx < 30'(C_NUM_RW)) begin
      region  = RegionRw;
      reg_idx = word_idx[IDX_W-1:0];
    end else if (word_idx < 30'(C_NUM_RW + C_NUM_RO)) begin
      region  = RegionRo;
      reg_idx = ro_idx[IDX_W-1:0];
    end
  end

  assign unused_bits = ^{offset[1:0], ro_idx[29:IDX_W]};

endmodule

// File: rtl/opb_swreg_slave.sv
// OPB slave exposing read/write registers to fabric and read-only registers from fabric.
module opb_swreg_slave
  import opb_swreg_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR = 32'h0100_0000,
  parameter logic [31:0] C_HIGHADDR = 32'h0100_FFFF,
  parameter int unsigned C_NUM_RW   = 4,
  parameter int unsigned C_NUM_RO   = 4
) (
  input  logic                  OPB_Clk,
  input  logic                  OPB_Rst,
  input  logic                  OPB_select,
  input  logic                  OPB_RNW,
  input  logic [0:31]           OPB_ABus,
  input  logic [0:3]            OPB_BE,
  input  logic                  OPB_seqAddr,
  input  logic [0:31]           OPB_DBus,
  output logic [0:31]           Sl_DBus,
  output logic                  Sl_xferAck,
  output logic                  Sl_errAck,
  output logic                  Sl_retry,
  output logic                  Sl_toutSup,
  output logic [C_NUM_RW*32-1:0] reg_out,
  output logic [C_NUM_RW-1:0]   reg_wr_stb,
  input  logic [C_NUM_RO*32-1:0] reg_in
);

  swreg_state_e          state_q, state_d;
  logic [OPB_AWIDTH-1:0] abus;
  logic                  hit;
  swreg_region_e         region, region_q;
  logic [IDX_W-1:0]      reg_idx, idx_q;
  logic                  rnw_q;
  logic [3:0]            be_q;
  logic [OPB_DWIDTH-1:0] wdata_q, rdata_q, rd_sel;
  logic [OPB_DWIDTH-1:0] regs_q [C_NUM_RW];
  logic                  unused_seq;

  assign abus       = OPB_ABus;
  assign unused_seq = OPB_seqAddr;
  assign Sl_retry   = 1'b0;

  opb_swreg_decode #(
    .C_BASEADDR (C_BASEADDR),
    .C_HIGHADDR (C_HIGHADDR),
    .C_NUM_RW   (C_NUM_RW),
    .C_NUM_RO   (C_NUM_RO)
  ) u_decode (
    .select  (OPB_select),
    .abus    (abus),
    .hit     (hit),
    .region  (region),
    .reg_idx (reg_idx)
  );

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // HOLD ignores select so a master slow to drop it is not acked twice.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (hit) state_d = StAck;
      StAck:   state_d = StHold;
      StHold:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rd_sel = '0;
    if (region == RegionRw) begin
      for (int i = 0; i < int'(C_NUM_RW); i++) begin
        if (reg_idx == IDX_W'(i)) rd_sel = regs_q[i];
      end
    end else if (region == RegionRo) begin
      for (int i = 0; i < int'(C_NUM_RO); i++) begin
        if (reg_idx == IDX_W'(i)) rd_sel = reg_in[32*i +: 32];
      end
    end
  end

  // Request fields are frozen at the IDLE->ACK edge.
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      region_q <= RegionUnmapped;
      idx_q    <= '0;
      rnw_q    <= 1'b0;
      be_q     <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else if (state_q == StIdle && hit) begin
      region_q <= region;
      idx_q    <= reg_idx;
      rnw_q    <= OPB_RNW;
      be_q     <= OPB_BE;
      wdata_q  <= OPB_DBus;
      rdata_q  <= rd_sel;
    end
  end

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      for (int i = 0; i < int'(C_NUM_RW); i++) regs_q[i] <= '0;
    end else if (state_q == StAck && !rnw_q && region_q == RegionRw) begin
      for (int i = 0; i < int'(C_NUM_RW); i++) begin
        if (idx_q == IDX_W'(i)) regs_q[i] <= be_merge(regs_q[i], wdata_q, be_q);
      end
    end
  end

  always_comb begin
    Sl_xferAck = 1'b0;
    Sl_errAck  = 1'b0;
    Sl_toutSup = 1'b0;
    Sl_DBus    = '0;
    reg_wr_stb = '0;
    if (state_q == StAck) begin
      Sl_xferAck = 1'b1;
      Sl_toutSup = 1'b1;
      Sl_errAck  = (region_q == RegionUnmapped);
      if (rnw_q && region_q != RegionUnmapped) Sl_DBus = rdata_q;
      if (!rnw_q && region_q == RegionRw) begin
        for (int i = 0; i < int'(C_NUM_RW); i++) begin
          if (idx_q == IDX_W'(i)) reg_wr_stb[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    reg_out = '0;
    for (int i = 0; i < int'(C_NUM_RW); i++) reg_out[32*i +: 32] = regs_q[i];
  end

endmodule

// File: tb/tb_opb_swreg_slave.sv
// Scoreboard bench for opb_swreg_slave: directed cases then randomized transfers.
module tb_opb_swreg_slave;

  localparam logic [31:0] BASE = 32'h0100_0000;
  localparam logic [31:0] HIGH = 32'h0100_FFFF;
  localparam int NRW = 4;
  localparam int NRO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;
  logic rnw = 1'b0;
  logic seq = 1'b0;
  logic [0:31] abus = '0;
  logic [0:31] dbus = '0;
  logic [0:3]  be_s = '0;
  logic [0:31] sl_dbus;
  logic        xack, eack, retry, tout;
  logic [NRW*32-1:0] reg_out;
  logic [NRW-1:0]    stb;
  logic [NRO*32-1:0] reg_in = '0;

  opb_swreg_slave #(
    .C_BASEADDR (BASE),
    .C_HIGHADDR (HIGH),
    .C_NUM_RW   (NRW),
    .C_NUM_RO   (NRO)
  ) dut (
    .OPB_Clk     (clk),
    .OPB_Rst     (rst),
    .OPB_select  (sel),
    .OPB_RNW     (rnw),
    .OPB_ABus    (abus),
    .OPB_BE      (be_s),
    .OPB_seqAddr (seq),
    .OPB_DBus    (dbus),
    .Sl_DBus     (sl_dbus),
    .Sl_xferAck  (xack),
    .Sl_errAck   (eack),
    .Sl_retry    (retry),
    .Sl_toutSup  (tout),
    .reg_out     (reg_out),
    .reg_wr_stb  (stb),
    .reg_in      (reg_in)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic           err;
    logic [31:0]    rdata;
    logic [NRW-1:0] stb;
    int             cyc;
  } exp_t;

  exp_t        q[$];
  logic [31:0] model_rw [NRW];
  logic [31:0] model_ro [NRO];
  int checks   = 0;
  int failures = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per ack; outside ack everything must be quiet.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (xack === 1'b1) begin
        if (q.size() == 0) begin
          check32("unexpected_ack", 32'(xack), 32'd0);
        end else begin
          e = q.pop_front();
          check32("ack_cycle", cyc, e.cyc);
          check32("err_ack", 32'(eack), 32'(e.err));
          check32("ack_dbus", sl_dbus, e.rdata);
          check32("ack_strobe", 32'(stb), 32'(e.stb));
          check32("ack_tout", 32'(tout), 32'd1);
        end
      end else begin
        check32("idle_dbus", sl_dbus, 32'd0);
        check32("idle_strobe", 32'(stb), 32'd0);
        check32("idle_flags", {29'd0, eack, tout, retry}, 32'd0);
      end
    end
  end

  task automatic apply_reg_in();
    for (int i = 0; i < NRO; i++) reg_in[32*i +: 32] = model_ro[i];
  endtask

  task automatic check_regs(input string name);
    for (int i = 0; i < NRW; i++) check32(name, reg_out[32*i +: 32], model_rw[i]);
  endtask

  // Called at a negedge with the slave idle; hold = sampling edges select stays high.
  task automatic xfer(input logic [31:0] addr, input logic is_rd, input logic [3:0] be,
                      input logic [31:0] d, input int hold);
    exp_t        e;
    int unsigned idx;
    abus = addr; rnw = is_rd; be_s = be; dbus = d; sel = 1'b1;
    if (addr >= BASE && addr <= HIGH) begin
      idx     = (addr - BASE) / 4;
      e.cyc   = cyc + 1;
      e.err   = 1'b0;
      e.rdata = '0;
      e.stb   = '0;
      if (idx < NRW) begin
        if (is_rd) e.rdata = model_rw[idx];
        else begin
          e.stb[idx] = 1'b1;
          for (int k = 0; k < 4; k++) if (be[k]) model_rw[idx][8*k +: 8] = d[8*k +: 8];
        end
      end else if (idx < NRW + NRO) begin
        if (is_rd) e.rdata = model_ro[idx - NRW];
      end else begin
        e.err = 1'b1;
      end
      q.push_back(e);
    end
    @(negedge clk);
    // Request lines change during the ack cycle and must be ignored.
    abus = $urandom; dbus = $urandom; be_s = 4'($urandom); rnw = 1'($urandom);
    repeat (hold - 1) @(negedge clk);
    sel = 1'b0; abus = '0; dbus = '0; be_s = '0; rnw = 1'b0;
    repeat (2) @(negedge clk);
    check_regs("reg_out");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int          kind;
    logic [31:0] addr;
    for (int i = 0; i < NRW; i++) model_rw[i] = '0;
    for (int i = 0; i < NRO; i++) model_ro[i] = '0;
    #1;
    check32("rst_flags", {28'd0, xack, eack, tout, retry}, 32'd0);
    check32("rst_dbus", sl_dbus, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_regs("rst_regs");

    // First hit after reset, full-word write.
    xfer(BASE, 1'b0, 4'b1111, 32'hDEAD_BEEF, 1);
    check32("reg0_deadbeef", reg_out[31:0], 32'hDEAD_BEEF);
    // Single byte lane write.
    xfer(BASE + 32'h4, 1'b0, 4'b0100, 32'h1122_3344, 1);
    check32("reg1_byte", reg_out[63:32], 32'h0022_0000);
    // Read of first read-only register.
    model_ro[0] = 32'hCAFE_0001;
    apply_reg_in();
    xfer(BASE + 32'h10, 1'b1, 4'b1111, 32'h0, 1);
    // Unmapped word inside the window.
    xfer(BASE + 32'h20, 1'b1, 4'b1111, 32'h0, 1);
    // Select held through ack and hold: one ack, one strobe.
    xfer(BASE + 32'h8, 1'b0, 4'b1111, 32'h5A5A_A5A5, 3);
    // Write to a read-only register is acked and discarded.
    xfer(BASE + 32'h14, 1'b0, 4'b1111, 32'h1234_5678, 1);
    // Out-of-window selects.
    xfer(BASE - 32'h4, 1'b0, 4'b1111, 32'hFFFF_FFFF, 1);
    xfer(HIGH + 32'h1, 1'b1, 4'b1111, 32'h0, 1);

    // Reset asserted during the ack of a write aborts it.
    abus = BASE; rnw = 1'b0; be_s = 4'b1111; dbus = 32'h0BAD_F00D; sel = 1'b1;
    @(posedge clk);
    #1;
    check32("ack_before_rst", 32'(xack), 32'd1);
    rst = 1'b1;
    #1;
    check32("ack_after_rst", {28'd0, xack, eack, tout, retry}, 32'd0);
    check32("strobe_after_rst", 32'(stb), 32'd0);
    check32("dbus_after_rst", sl_dbus, 32'd0);
    sel = 1'b0;
    for (int i = 0; i < NRW; i++) model_rw[i] = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_regs("regs_after_abort");
    check32("reg0_after_abort", reg_out[31:0], 32'h0);
    xfer(BASE + 32'hC, 1'b1, 4'b1111, 32'h0, 1);

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int i = 0; i < NRO; i++) model_ro[i] = $urandom;
        apply_reg_in();
      end
      kind = $urandom_range(0, 5);
      case (kind)
        0, 1:    addr = BASE + 32'($urandom_range(0, NRW - 1) * 4);
        2:       addr = BASE + 32'((NRW + $urandom_range(0, NRO - 1)) * 4);
        3:       addr = BASE + 32'($urandom_range(NRW + NRO, 16383) * 4);
        4:       addr = BASE - 32'($urandom_range(1, 4096));
        default: addr = HIGH + 32'($urandom_range(1, 4096));
      endcase
      if (kind <= 3) addr[1:0] = 2'($urandom);
      xfer(addr, 1'($urandom), 4'($urandom), $urandom,
           (kind <= 3) ? $urandom_range(1, 3) : 1);
    end

    repeat (3) @(negedge clk);
    check32("pending_acks", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
